axis_meta_inserter: RTL and testbench

AXIS_META_INSERTER -- requirements
Module: axis_meta_inserter

---
 rtl/axis_meta_inserter.sv | 213 +++++++++++++++++++++
 tb/tb_axis_meta_inserter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_meta_inserter.sv
// axis_meta_inserter: buffers an AXI-Stream payload and a per-packet metadata
// stream, and emits each packet preceded by one header beat carrying its
// metadata (or passes packets straight through when HDR_EN = 0).
//
// state | meaning
// IDLE  | between packets; waiting for payload (and metadata when HDR_EN)
// HDR   | header beat loaded into the output register
// PAY   | streaming payload beats of the current packet
module axis_meta_inserter #(
  parameter int DATA_W     = 512,
  parameter int META_W     = 356,
  parameter int PAY_DEPTH  = 16,
  parameter int META_DEPTH = 4,
  parameter bit HDR_EN     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            s_tdata,
  input  logic [DATA_W/8-1:0]          s_tkeep,
  input  logic                         s_tlast,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [META_W-1:0]            meta_data,
  input  logic                         meta_valid,
  output logic                         meta_ready,
  output logic [DATA_W-1:0]            m_tdata,
  output logic [DATA_W/8-1:0]          m_tkeep,
  output logic                         m_tlast,
  output logic                         m_tuser,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [15:0]                  pkt_sent,
  output logic [$clog2(PAY_DEPTH):0]   pay_level
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PAW    = $clog2(PAY_DEPTH);
  localparam int MAW    = $clog2(META_DEPTH);
  localparam int PAY_W  = DATA_W + KEEP_W + 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_PAY = 2'd2} state_t;

  state_t r_state, w_state_nxt;

  logic [PAY_W-1:0]  r_pay_mem [PAY_DEPTH];
  logic [PAW:0]      r_pay_wr, r_pay_rd;
  logic              w_pay_full, w_pay_empty, w_pay_push, w_pay_pop;
  logic [PAY_W-1:0]  w_pay_head;
  logic [DATA_W-1:0] w_pay_data;
  logic [KEEP_W-1:0] w_pay_keep;
  logic              w_pay_last;

  logic [META_W-1:0] r_meta_mem [META_DEPTH];
  logic [MAW:0]      r_meta_wr, r_meta_rd;
  logic              w_meta_full, w_meta_empty, w_meta_push, w_meta_pop;
  logic [META_W-1:0] w_meta_head;
  logic [DATA_W-1:0] w_hdr_data;

  logic              w_can_load, w_ld_hdr, w_ld_pay;
  logic [DATA_W-1:0] r_m_tdata;
  logic [KEEP_W-1:0] r_m_tkeep;
  logic              r_m_tlast, r_m_tuser, r_m_tvalid;
  logic [15:0]       r_pkt_sent;

  // ---------------- payload FIFO (first-word-fall-through) ----------------
  assign w_pay_empty = (r_pay_wr == r_pay_rd);
  assign w_pay_full  = (r_pay_wr[PAW] != r_pay_rd[PAW]) &&
                       (r_pay_wr[PAW-1:0] == r_pay_rd[PAW-1:0]);
  assign s_tready    = !w_pay_full && !rst;
  assign w_pay_push  = s_tvalid && s_tready;
  assign w_pay_head  = r_pay_mem[r_pay_rd[PAW-1:0]];
  assign {w_pay_last, w_pay_keep, w_pay_data} = w_pay_head;
  assign pay_level   = r_pay_wr - r_pay_rd;

  // Payload storage; the pointers alone decide what is valid, so no reset.
  always_ff @(posedge clk) begin
    if (w_pay_push) r_pay_mem[r_pay_wr[PAW-1:0]] <= {s_tlast, s_tkeep, s_tdata};
  end

  // Payload pointers; push and pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pay_wr <= '0;
      r_pay_rd <= '0;
    end else begin
      if (w_pay_push) r_pay_wr <= r_pay_wr + {{PAW{1'b0}}, 1'b1};
      if (w_pay_pop)  r_pay_rd <= r_pay_rd + {{PAW{1'b0}}, 1'b1};
    end
  end

  // ---------------- metadata FIFO (first-word-fall-through) ----------------
  assign w_meta_empty = (r_meta_wr == r_meta_rd);
  assign w_meta_full  = (r_meta_wr[MAW] != r_meta_rd[MAW]) &&
                        (r_meta_wr[MAW-1:0] == r_meta_rd[MAW-1:0]);
  // Without headers the metadata is simply swallowed.
  assign meta_ready   = HDR_EN ? (!w_meta_full && !rst) : 1'b1;
  assign w_meta_push  = HDR_EN && meta_valid && meta_ready;
  assign w_meta_head  = r_meta_mem[r_meta_rd[MAW-1:0]];

  // Metadata storage.
  always_ff @(posedge clk) begin
    if (w_meta_push) r_meta_mem[r_meta_wr[MAW-1:0]] <= meta_data;
  end

  // Metadata pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta_wr <= '0;
      r_meta_rd <= '0;
    end else begin
      if (w_meta_push) r_meta_wr <= r_meta_wr + {{MAW{1'b0}}, 1'b1};
      if (w_meta_pop)  r_meta_rd <= r_meta_rd + {{MAW{1'b0}}, 1'b1};
    end
  end

  // Header beat carries the metadata zero-extended to the stream width.
  always_comb begin
    w_hdr_data = '0;
    w_hdr_data[META_W-1:0] = w_meta_head;
  end

  // ---------------- sequencing FSM ----------------
  assign w_can_load = !r_m_tvalid || m_tready;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decision.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_can_load) begin
          if (HDR_EN) begin
            if (!w_pay_empty && !w_meta_empty) w_state_nxt = ST_HDR;
          end else if (!w_pay_empty && !w_pay_last) begin
            w_state_nxt = ST_PAY;
          end
        end
      end
      ST_HDR, ST_PAY: begin
        if (w_can_load) begin
          if (!w_pay_empty) w_state_nxt = w_pay_last ? ST_IDLE : ST_PAY;
          else              w_state_nxt = ST_PAY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Load/pop strobes for the current state.
  always_comb begin
    w_ld_hdr = 1'b0;
    w_ld_pay = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_can_load) begin
          if (HDR_EN) w_ld_hdr = !w_pay_empty && !w_meta_empty;
          else        w_ld_pay = !w_pay_empty;
        end
      end
      ST_HDR, ST_PAY: w_ld_pay = w_can_load && !w_pay_empty;
      default: ;
    endcase
  end

  assign w_pay_pop  = w_ld_pay;
  assign w_meta_pop = w_ld_hdr;

  // Output register; only moves when empty or being accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (w_can_load) begin
      if (w_ld_hdr) begin
        r_m_tdata  <= w_hdr_data;
        r_m_tkeep  <= '1;
        r_m_tlast  <= 1'b0;
        r_m_tuser  <= 1'b1;
        r_m_tvalid <= 1'b1;
      end else if (w_ld_pay) begin
        r_m_tdata  <= w_pay_data;
        r_m_tkeep  <= w_pay_keep;
        r_m_tlast  <= w_pay_last;
        r_m_tuser  <= 1'b0;
        r_m_tvalid <= 1'b1;
      end else begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  // Completed-packet counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pkt_sent <= '0;
    else if (r_m_tvalid && m_tready && r_m_tlast) r_pkt_sent <= r_pkt_sent + 16'd1;
  end

  assign m_tdata  = r_m_tdata;
  assign m_tkeep  = r_m_tkeep;
  assign m_tlast  = r_m_tlast;
  assign m_tuser  = r_m_tuser;
  assign m_tvalid = r_m_tvalid;
  assign pkt_sent = r_pkt_sent;

endmodule

// File: tb/tb_axis_meta_inserter.sv
// Testbench for axis_meta_inserter: directed vector table, multi-cycle corner
// sequences and a randomized run against a packet-order reference model.
module tb_axis_meta_inserter;

  localparam int DW = 64;
  localparam int MW = 40;
  localparam int KW = DW / 8;
  localparam int PD = 16;
  localparam int MD = 4;
  localparam int LW = $clog2(PD) + 1;

  typedef struct packed {
    logic          user;
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int            len;
    logic [MW-1:0] meta;
    logic [KW-1:0] last_keep;
    int            exp_beats;
    logic [8:0]    exp_user;
    logic [8:0]    exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast, s_tvalid, s_tready;
  logic [MW-1:0] meta_data;
  logic          meta_valid, meta_ready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast, m_tuser, m_tvalid, m_tready;
  logic [15:0]   pkt_sent;
  logic [LW-1:0] pay_level;

  logic          p_svalid, p_sready, p_meta_ready, p_mready;
  logic [DW-1:0] p_tdata;
  logic [KW-1:0] p_tkeep;
  logic          p_tlast, p_tuser, p_tvalid;
  logic [15:0]   p_pkt_sent;
  logic [LW-1:0] p_pay_level;

  axis_meta_inserter #(.DATA_W(DW), .META_W(MW), .PAY_DEPTH(PD), .META_DEPTH(MD), .HDR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .meta_data(meta_data), .meta_valid(meta_valid), .meta_ready(meta_ready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .pkt_sent(pkt_sent), .pay_level(pay_level)
  );

  axis_meta_inserter #(.DATA_W(DW), .META_W(MW), .PAY_DEPTH(PD), .META_DEPTH(MD), .HDR_EN(1'b0)) dut_pt (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(p_svalid), .s_tready(p_sready),
    .meta_data(meta_data), .meta_valid(meta_valid), .meta_ready(p_meta_ready),
    .m_tdata(p_tdata), .m_tkeep(p_tkeep), .m_tlast(p_tlast), .m_tuser(p_tuser),
    .m_tvalid(p_tvalid), .m_tready(p_mready),
    .pkt_sent(p_pkt_sent), .pay_level(p_pay_level)
  );

  int    n_pass  = 0;
  int    n_total = 0;
  int    cyc     = 0;
  int    exp_pkts = 0;
  bit    done_rand = 1'b0;
  beat_t obs[$];
  int    obs_cyc[$];
  beat_t obs0[$];
  beat_t exp_q[$];
  beat_t prev_b;
  bit    prev_stall = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  task automatic fail_to(input string nm);
    n_total++;
    $display("FAIL %s: wait bound expired before the event occurred", nm);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pdata(input int a, input int b);
    logic [31:0] ha, hb;
    ha = a;
    hb = b;
    return {ha + 32'hC0DE_0000, hb ^ 32'h5A5A_5A5A};
  endfunction

  function automatic beat_t hdr_beat(input logic [MW-1:0] md);
    beat_t b;
    b.user = 1'b1;
    b.last = 1'b0;
    b.keep = '1;
    b.data = {{(DW-MW){1'b0}}, md};
    return b;
  endfunction

  function automatic beat_t pay_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    beat_t b;
    b.user = 1'b0;
    b.last = l;
    b.keep = k;
    b.data = d;
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records accepted beats and checks that stalled beats hold.
  always @(negedge clk) begin : mon
    beat_t cur;
    cur = {m_tuser, m_tlast, m_tkeep, m_tdata};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {m_tvalid, cur}, {1'b1, prev_b});
      if (m_tvalid && m_tready) begin
        obs.push_back(cur);
        obs_cyc.push_back(cyc);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_b     = cur;
      if (p_tvalid && p_mready) obs0.push_back({p_tuser, p_tlast, p_tkeep, p_tdata});
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int t;
    t = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && t < 2000) begin @(negedge clk); t++; end
    if (!s_tready) fail_to("s_accept");
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_meta(input logic [MW-1:0] md);
    int t;
    t = 0;
    meta_data = md; meta_valid = 1'b1;
    @(negedge clk);
    while (!meta_ready && t < 2000) begin @(negedge clk); t++; end
    if (!meta_ready) fail_to("meta_accept");
    @(posedge clk); #1;
    meta_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int lim);
    int t;
    t = 0;
    while (obs.size() < n && t < lim) begin @(negedge clk); t++; end
    if (obs.size() < n) fail_to("output_beats");
  endtask

  task automatic cmp_queue(input string nm);
    chk({nm, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) chk(nm, obs[i], exp_q[i]);
  endtask

  task automatic clear_obs();
    obs.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  vec_t          vecs[4];
  logic [8:0]    u_m, l_m;
  bit            saw;
  beat_t         rp_beats[$];
  logic [MW-1:0] rp_meta[$];

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 40'h11_2233_4455, 8'hFF, 2, 9'b000000001, 9'b000000010};
    vecs[1] = '{3, 40'hAB_CDEF_0123, 8'hFF, 4, 9'b000000001, 9'b000001000};
    vecs[2] = '{5, 40'h80_0000_0001, 8'h0F, 6, 9'b000000001, 9'b000100000};
    vecs[3] = '{2, 40'hFF_FFFF_FFFF, 8'h01, 3, 9'b000000001, 9'b000000100};

    rst = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    meta_data = '0; meta_valid = 1'b0; m_tready = 1'b0;
    p_svalid = 1'b0; p_mready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_bus", {m_tuser, m_tlast, m_tkeep, m_tdata}, 0);
    chk("rst_pkt_sent", pkt_sent, 0);
    chk("rst_pay_level", pay_level, 0);
    chk("rst_readies", {s_tready, meta_ready}, 2'b00);
    chk("rst_pt_meta_ready", p_meta_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_readies", {s_tready, meta_ready}, 2'b11);
    sync();

    // Directed vector table, output always ready.
    m_tready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      clear_obs();
      send_meta(vecs[v].meta);
      for (int i = 0; i < vecs[v].len; i++)
        send_beat(pdata(v, i), (i == vecs[v].len - 1) ? vecs[v].last_keep : {KW{1'b1}},
                  i == vecs[v].len - 1);
      wait_obs(vecs[v].exp_beats, 200);
      repeat (3) @(negedge clk);
      chk("vec_count", obs.size(), vecs[v].exp_beats);
      u_m = '0; l_m = '0;
      for (int i = 0; i < obs.size() && i < 9; i++) begin
        u_m[i] = obs[i].user;
        l_m[i] = obs[i].last;
      end
      chk("vec_tuser", u_m, vecs[v].exp_user);
      chk("vec_tlast", l_m, vecs[v].exp_last);
      if (obs.size() > 0) chk("vec_hdr_data", obs[0].data, {{(DW-MW){1'b0}}, vecs[v].meta});
      for (int i = 1; i < obs.size() && i <= vecs[v].len; i++) begin
        chk("vec_pay_data", obs[i].data, pdata(v, i - 1));
        chk("vec_pay_keep", obs[i].keep, (i == vecs[v].len) ? vecs[v].last_keep : {KW{1'b1}});
      end
      exp_pkts++;
      chk("vec_pkt_sent", pkt_sent, exp_pkts);
      sync();
    end

    // Payload arrives long before its metadata.
    clear_obs();
    send_beat(pdata(50, 0), '1, 1'b0);
    send_beat(pdata(50, 1), 8'h3F, 1'b1);
    saw = 1'b0;
    repeat (10) begin @(negedge clk); if (m_tvalid) saw = 1'b1; end
    chk("early_valid", saw, 0);
    sync();
    send_meta(40'h5E_ED00_BEEF);
    @(negedge clk);
    chk("hdr_latency_pre", m_tvalid, 0);
    @(negedge clk);
    chk("hdr_latency", {m_tvalid, m_tuser}, 2'b11);
    wait_obs(3, 50);
    repeat (3) @(negedge clk);
    exp_q.push_back(hdr_beat(40'h5E_ED00_BEEF));
    exp_q.push_back(pay_beat(pdata(50, 0), '1, 1'b0));
    exp_q.push_back(pay_beat(pdata(50, 1), 8'h3F, 1'b1));
    cmp_queue("late_meta");
    if (obs_cyc.size() >= 3) chk("back_to_back", obs_cyc[2] - obs_cyc[0], 2);
    exp_pkts++;
    chk("late_pkt_sent", pkt_sent, exp_pkts);
    sync();

    // Output blocked: payload FIFO fills, then drains intact.
    clear_obs();
    m_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_beat(pdata(60, i), '1, i == 19);
      end
    join_none
    repeat (30) @(negedge clk);
    chk("full_level", pay_level, PD);
    chk("full_s_tready", s_tready, 0);
    chk("full_no_output", m_tvalid, 0);
    sync();
    m_tready = 1'b1;
    send_meta(40'h00_0000_0028);
    wait fork;
    wait_obs(21, 500);
    repeat (3) @(negedge clk);
    exp_q.push_back(hdr_beat(40'h00_0000_0028));
    for (int i = 0; i < 20; i++) exp_q.push_back(pay_beat(pdata(60, i), '1, i == 19));
    cmp_queue("full_drain");
    exp_pkts++;
    chk("full_pkt_sent", pkt_sent, exp_pkts);
    sync();

    // Randomized packets with random backpressure against the ordering model.
    clear_obs();
    rp_beats.delete();
    rp_meta.delete();
    for (int p = 0; p < 20; p++) begin
      logic [MW-1:0] md;
      int len;
      md  = MW'({$urandom(), $urandom()});
      len = $urandom_range(1, 8);
      rp_meta.push_back(md);
      exp_q.push_back(hdr_beat(md));
      for (int i = 0; i < len; i++) begin
        beat_t b;
        b = pay_beat({$urandom(), $urandom()},
                     (i == len - 1) ? KW'($urandom_range(1, 255)) : {KW{1'b1}}, i == len - 1);
        rp_beats.push_back(b);
        exp_q.push_back(b);
      end
    end
    done_rand = 1'b0;
    fork
      begin
        while (!done_rand) begin
          @(posedge clk); #1;
          m_tready = ($urandom_range(0, 2) != 0);
        end
      end
    join_none
    fork
      begin
        foreach (rp_meta[i]) begin
          repeat ($urandom_range(0, 6)) sync();
          send_meta(rp_meta[i]);
        end
      end
      begin
        foreach (rp_beats[i]) begin
          repeat ($urandom_range(0, 2)) sync();
          send_beat(rp_beats[i].data, rp_beats[i].keep, rp_beats[i].last);
        end
      end
    join
    wait_obs(exp_q.size(), 5000);
    done_rand = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    cmp_queue("random");
    exp_pkts += 20;
    chk("random_pkt_sent", pkt_sent, exp_pkts);
    sync();

    // Reset in the middle of a packet.
    clear_obs();
    m_tready = 1'b0;
    send_meta(40'h77_7777_7777);
    for (int i = 0; i < 5; i++) send_beat(pdata(70, i), '1, i == 4);
    m_tready = 1'b1;
    begin
      int t;
      t = 0;
      while (obs.size() < 3 && t < 100) begin @(negedge clk); t++; end
      if (obs.size() < 3) fail_to("pre_reset_beats");
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_m_bus", {m_tuser, m_tlast, m_tkeep, m_tdata}, 0);
    chk("midrst_pkt_sent", pkt_sent, 0);
    chk("midrst_pay_level", pay_level, 0);
    chk("midrst_readies", {s_tready, meta_ready}, 2'b00);
    rst = 1'b0;
    exp_pkts = 0;
    @(negedge clk);
    chk("midrst_release", {s_tready, meta_ready, m_tvalid}, 3'b110);
    sync();
    clear_obs();
    send_meta(40'h12_3456_789A);
    for (int i = 0; i < 3; i++) send_beat(pdata(80, i), (i == 2) ? 8'h7F : {KW{1'b1}}, i == 2);
    wait_obs(4, 200);
    repeat (3) @(negedge clk);
    exp_q.push_back(hdr_beat(40'h12_3456_789A));
    for (int i = 0; i < 3; i++) exp_q.push_back(pay_beat(pdata(80, i), (i == 2) ? 8'h7F : {KW{1'b1}}, i == 2));
    cmp_queue("after_rst");
    exp_pkts++;
    chk("after_rst_pkt_sent", pkt_sent, exp_pkts);
    sync();

    // Pass-through instance: output equals input, no header.
    obs0.delete();
    p_mready = 1'b1;
    meta_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      int t;
      t = 0;
      s_tdata = pdata(90, i); s_tkeep = (i == 1) ? 8'hC3 : 8'hFF; s_tlast = (i == 1);
      p_svalid = 1'b1;
      @(negedge clk);
      chk("pt_meta_ready", p_meta_ready, 1);
      while (!p_sready && t < 100) begin @(negedge clk); t++; end
      if (!p_sready) fail_to("pt_accept");
      @(posedge clk); #1;
      p_svalid = 1'b0;
    end
    meta_valid = 1'b0;
    begin
      int t;
      t = 0;
      while (obs0.size() < 2 && t < 100) begin @(negedge clk); t++; end
      if (obs0.size() < 2) fail_to("pt_output");
    end
    repeat (3) @(negedge clk);
    chk("pt_count", obs0.size(), 2);
    for (int i = 0; i < obs0.size() && i < 2; i++)
      chk("pt_beat", obs0[i], pay_beat(pdata(90, i), (i == 1) ? 8'hC3 : 8'hFF, i == 1));
    chk("pt_pkt_sent", p_pkt_sent, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
